// File: rtl/traffic_pkg.sv
// Shared encodings for the multi-approach traffic controller: lamp codes,
// phase encoding and lamp field width.
package traffic_pkg;

  localparam int LAMP_W = 2;

  typedef enum logic [1:0] {
    LAMP_GREEN  = 2'b00,
    LAMP_YELLOW = 2'b01,
    LAMP_RED    = 2'b10
  } lamp_e;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10,
    PH_EMERG  = 2'b11
  } phase_e;

endpackage

// File: rtl/rr_next_picker.sv
// Combinational round-robin search: nearest requesting index after cur,
// wrapping, excluding cur itself.
module rr_next_picker
  import traffic_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   cur,
  output logic [IDX_W-1:0]   nxt,
  output logic               found
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum_v;
    sum_v = int'(base) + off;
    sum_v = (sum_v >= NUM_REQ) ? (sum_v - NUM_REQ) : sum_v;
    return IDX_W'(sum_v);
  endfunction

  // Scan farthest-to-nearest so the nearest requester wins the last assignment.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 1; k--) begin
      nxt   = req[wrap_add(cur, k)] ? wrap_add(cur, k) : nxt;
      found = found | req[wrap_add(cur, k)];
    end
  end

endmodule

// File: rtl/multi_approach_traffic_controller.sv
// Round-robin traffic controller for NUM_APPROACHES approaches with min/max
// green, yellow, all-red clearance and an emergency all-red override.
module multi_approach_traffic_controller
  import traffic_pkg::*;
#(
  parameter int NUM_APPROACHES = 2,
  parameter int GREEN_MIN      = 3,
  parameter int GREEN_MAX      = 6,
  parameter int YELLOW_TIME    = 2,
  parameter int ALL_RED_TIME   = 1,
  parameter int CNT_W          = 8,
  parameter int IDX_W          = $clog2(NUM_APPROACHES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic [NUM_APPROACHES-1:0]   traffic,
  input  logic                        emerg,
  output logic [2*NUM_APPROACHES-1:0] lights,
  output logic [IDX_W-1:0]            active_idx,
  output logic [1:0]                  phase
);

  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALL_RED_TIME - 1);

  generate
    if (NUM_APPROACHES < 2) begin : g_bad_num
      $error("NUM_APPROACHES must be at least 2");
    end
    if (IDX_W != $clog2(NUM_APPROACHES)) begin : g_bad_idx
      $error("IDX_W must equal clog2(NUM_APPROACHES)");
    end
    if ((GREEN_MIN < 1) || (GREEN_MAX < GREEN_MIN)) begin : g_bad_green
      $error("green limits must satisfy 1 <= GREEN_MIN <= GREEN_MAX");
    end
    if ((YELLOW_TIME < 1) || (ALL_RED_TIME < 0)) begin : g_bad_dwell
      $error("YELLOW_TIME must be >= 1 and ALL_RED_TIME >= 0");
    end
    if ((CNT_W < 31) && ((GREEN_MAX >= (1 << CNT_W)) || (YELLOW_TIME >= (1 << CNT_W)) ||
                         (ALL_RED_TIME >= (1 << CNT_W)))) begin : g_bad_cnt
      $error("CNT_W too narrow for the configured dwell times");
    end
  endgenerate

  function automatic logic [2*NUM_APPROACHES-1:0] lamp_map(input phase_e ph,
                                                           input logic [IDX_W-1:0] idx);
    logic [2*NUM_APPROACHES-1:0] l;
    for (int i = 0; i < NUM_APPROACHES; i++) begin
      if ((ph == PH_GREEN) && (IDX_W'(i) == idx)) begin
        l[LAMP_W*i +: LAMP_W] = LAMP_GREEN;
      end else if ((ph == PH_YELLOW) && (IDX_W'(i) == idx)) begin
        l[LAMP_W*i +: LAMP_W] = LAMP_YELLOW;
      end else begin
        l[LAMP_W*i +: LAMP_W] = LAMP_RED;
      end
    end
    return l;
  endfunction

  phase_e                      phase_r, phase_s;
  logic [IDX_W-1:0]            active_idx_r, active_idx_s;
  logic [IDX_W-1:0]            next_idx_r, next_idx_s;
  logic [CNT_W-1:0]            timer_r, timer_s;
  logic [2*NUM_APPROACHES-1:0] lights_r;
  logic [IDX_W-1:0]            pick_idx_s;
  logic                        pick_found_s;
  logic                        own_s;

  rr_next_picker #(
    .NUM_REQ (NUM_APPROACHES),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (traffic),
    .cur   (active_idx_r),
    .nxt   (pick_idx_s),
    .found (pick_found_s)
  );

  assign own_s = traffic[active_idx_r];

  // Next-state logic; nothing moves unless tick is high.
  always_comb begin
    phase_s      = phase_r;
    active_idx_s = active_idx_r;
    next_idx_s   = next_idx_r;
    timer_s      = timer_r;
    if (tick) begin
      case (phase_r)
        PH_GREEN: begin
          if (emerg || (pick_found_s && (timer_r >= GMIN_M1) &&
                        (!own_s || (timer_r >= GMAX_M1)))) begin
            phase_s    = PH_YELLOW;
            timer_s    = {CNT_W{1'b0}};
            next_idx_s = pick_found_s ? pick_idx_s : active_idx_r;
          end else begin
            timer_s = (timer_r >= GMAX_M1) ? GMAX_M1 : (timer_r + CNT_W'(1));
          end
        end
        PH_YELLOW: begin
          if (timer_r == YEL_M1) begin
            timer_s = {CNT_W{1'b0}};
            if (ALL_RED_TIME != 0) begin
              phase_s = PH_ALLRED;
            end else if (emerg) begin
              phase_s = PH_EMERG;
            end else begin
              phase_s      = PH_GREEN;
              active_idx_s = next_idx_r;
            end
          end else begin
            timer_s = timer_r + CNT_W'(1);
          end
        end
        PH_ALLRED: begin
          if (timer_r == AR_M1) begin
            timer_s = {CNT_W{1'b0}};
            if (emerg) begin
              phase_s = PH_EMERG;
            end else begin
              phase_s      = PH_GREEN;
              active_idx_s = next_idx_r;
            end
          end else begin
            timer_s = timer_r + CNT_W'(1);
          end
        end
        PH_EMERG: begin
          if (!emerg) begin
            phase_s      = PH_GREEN;
            active_idx_s = next_idx_r;
            timer_s      = {CNT_W{1'b0}};
          end else begin
            timer_s = timer_r + CNT_W'(1);
          end
        end
        default: begin
          phase_s = PH_ALLRED;
          timer_s = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      phase_s = phase_r;
    end
  end

  // State registers; lamp outputs are registered from the next state so they
  // change on the same edge as phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r      <= PH_GREEN;
      active_idx_r <= {IDX_W{1'b0}};
      next_idx_r   <= {IDX_W{1'b0}};
      timer_r      <= {CNT_W{1'b0}};
      lights_r     <= lamp_map(PH_GREEN, {IDX_W{1'b0}});
    end else begin
      phase_r      <= phase_s;
      active_idx_r <= active_idx_s;
      next_idx_r   <= next_idx_s;
      timer_r      <= timer_s;
      lights_r     <= lamp_map(phase_s, active_idx_s);
    end
  end

  assign lights     = lights_r;
  assign active_idx = active_idx_r;
  assign phase      = phase_r;

endmodule
